// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single UART transmitter.
// Define UART_ARB_LOCK_EN to hold the grant across a packet until its last byte.
module uart_tx_arbiter #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [1:0] grant,
  output logic       err_timeout
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;

  state_t         r_state;
  logic           r_ptr;
  logic           r_armed;
  logic [CW-1:0]  r_cnt;
  logic           r_tx_start;
  logic [7:0]     r_tx_data;
  logic [1:0]     r_grant;
  logic           r_err;
  logic           r_lock;

  logic       w_elig0, w_elig1, w_accept, w_win, w_last;
  logic [7:0] w_data;

`ifdef UART_ARB_LOCK_EN
  logic r_lock_id;
  assign w_elig0 = req0_valid && (!r_lock || !r_lock_id);
  assign w_elig1 = req1_valid && (!r_lock ||  r_lock_id);
`else
  logic w_unused_last;
  assign w_unused_last = req0_last ^ req1_last;
  assign w_elig0 = req0_valid;
  assign w_elig1 = req1_valid;
`endif

  // r_armed keeps the first cycle after reset release from accepting.
  assign w_accept   = (r_state == IDLE) && r_armed && !tx_busy && (w_elig0 || w_elig1);
  assign w_win      = (w_elig0 && w_elig1) ? r_ptr : w_elig1;
  assign w_data     = w_win ? req1_data : req0_data;
  assign w_last     = w_win ? req1_last : req0_last;
  assign req0_ready = w_accept && !w_win;
  assign req1_ready = w_accept &&  w_win;

  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign grant       = r_grant;
  assign err_timeout = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= 1'b0;
      r_armed    <= 1'b0;
      r_cnt      <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_grant    <= 2'b00;
      r_err      <= 1'b0;
      r_lock     <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      r_lock_id  <= 1'b0;
`endif
    end else begin
      r_armed    <= 1'b1;
      r_tx_start <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_tx_data  <= w_data;
            r_grant    <= w_win ? 2'b10 : 2'b01;
            r_tx_start <= 1'b1;
            r_state    <= START;
`ifdef UART_ARB_LOCK_EN
            // Pointer only moves once the packet is complete.
            if (w_last) begin
              r_lock <= 1'b0;
              r_ptr  <= !w_win;
            end else begin
              r_lock    <= 1'b1;
              r_lock_id <= w_win;
            end
`else
            r_ptr <= !w_win;
`endif
          end
        end
        START: begin
          r_cnt   <= '0;
          r_state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (tx_busy) begin
            r_state <= WAIT_DONE;
          end else if (r_cnt == CW'(ACK_TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_grant <= 2'b00;
            r_lock  <= 1'b0;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            r_state <= IDLE;
            if (!r_lock) r_grant <= 2'b00;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Pure helper so the last-flag mux is always consumed.
  logic w_unused_lastsel;
  assign w_unused_lastsel = w_last;
endmodule
